// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, load, logical/arithmetic shift, rotate and clear,
// with complemented output, registered carry-out and a combinational zero flag.
module univ_shift_reg #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_reg, q_next;
  logic             co_reg, co_next;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_next  = q_reg;
    co_next = co_reg;
    if (en) begin
      case (mode_sel)
        MODE_LOAD: begin
          q_next  = d;
          co_next = 1'b0;
        end
        MODE_SHL: begin
          q_next  = {q_reg[WIDTH-2:0], sin_l};
          co_next = q_reg[WIDTH-1];
        end
        MODE_SHR: begin
          q_next  = {sin_r, q_reg[WIDTH-1:1]};
          co_next = q_reg[0];
        end
        MODE_ROL: begin
          q_next  = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          co_next = q_reg[WIDTH-1];
        end
        MODE_ROR: begin
          q_next  = {q_reg[0], q_reg[WIDTH-1:1]};
          co_next = q_reg[0];
        end
        MODE_ASR: begin
          q_next  = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
          co_next = q_reg[0];
        end
        MODE_CLR: begin
          q_next  = '0;
          co_next = 1'b0;
        end
        default: begin
          q_next  = q_reg;
          co_next = co_reg;
        end
      endcase
    end
  end

  // Reset wins over any operation in flight; nothing is partially committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= RESET_VALUE;
      co_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      co_reg <= co_next;
    end
  end

  // nq comes straight from the same flops as q, so the two can never disagree.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_nq
      assign nq[gi] = ~q_reg[gi];
    end
  endgenerate

  assign q    = q_reg;
  assign co   = co_reg;
  assign zero = (q_reg == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit (reset 0x5A) and a 4-bit (reset 0) instance,
// checked against an arithmetic reference model plus fixed vector tables.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en8 = 1'b0, sl8 = 1'b0, sr8 = 1'b0;
  logic [2:0] mode8 = 3'd0;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8, nq8;
  logic       co8, z8;

  logic       en4 = 1'b0, sl4 = 1'b0, sr4 = 1'b0;
  logic [2:0] mode4 = 3'd0;
  logic [3:0] d4 = 4'h0;
  logic [3:0] q4, nq4;
  logic       co4, z4;

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .d(d8), .sin_l(sl8), .sin_r(sr8),
    .q(q8), .nq(nq8), .co(co8), .zero(z8)
  );

  univ_shift_reg #(.WIDTH(4), .RESET_VALUE(4'h0)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .d(d4), .sin_l(sl4), .sin_r(sr4),
    .q(q4), .nq(nq4), .co(co4), .zero(z4)
  );

  int checks = 0;
  int failures = 0;

  // Reference state of both instances
  int m8_q, m8_co, m4_q, m4_co;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Next state from the mode rules, using integer arithmetic on a w-bit word.
  function automatic void ref_next(input int w, input int q, input int c, input logic en,
                                   input int mode, input int d, input logic sl, input logic sr,
                                   output int nq_o, output int nco_o);
    int m, half, msb, lsb;
    m    = 1 << w;
    half = m / 2;
    msb  = q / half;
    lsb  = q % 2;
    nq_o  = q;
    nco_o = c;
    if (en) begin
      case (mode)
        1: begin nq_o = d % m;                      nco_o = 0;   end
        2: begin nq_o = (q * 2 + int'(sl)) % m;     nco_o = msb; end
        3: begin nq_o = q / 2 + int'(sr) * half;    nco_o = lsb; end
        4: begin nq_o = (q * 2) % m + msb;          nco_o = msb; end
        5: begin nq_o = q / 2 + lsb * half;         nco_o = lsb; end
        6: begin nq_o = q / 2 + msb * half;         nco_o = lsb; end
        7: begin nq_o = 0;                          nco_o = 0;   end
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " q8"},    32'(q8),  32'(m8_q));
    chk({tag, " nq8"},   32'(nq8), 32'(255 - m8_q));
    chk({tag, " co8"},   32'(co8), 32'(m8_co));
    chk({tag, " zero8"}, 32'(z8),  32'(m8_q == 0));
    chk({tag, " q4"},    32'(q4),  32'(m4_q));
    chk({tag, " nq4"},   32'(nq4), 32'(15 - m4_q));
    chk({tag, " co4"},   32'(co4), 32'(m4_co));
    chk({tag, " zero4"}, 32'(z4),  32'(m4_q == 0));
  endtask

  task automatic set_reset_model();
    m8_q = 'h5A; m8_co = 0; m4_q = 0; m4_co = 0;
  endtask

  // One clock edge with the currently driven inputs; checks just after the edge.
  task automatic tick(input string tag);
    int n8q, n8c, n4q, n4c;
    n8q = m8_q; n8c = m8_co; n4q = m4_q; n4c = m4_co;
    if (!rst) begin
      ref_next(8, m8_q, m8_co, en8, int'(mode8), int'(d8), sl8, sr8, n8q, n8c);
      ref_next(4, m4_q, m4_co, en4, int'(mode4), int'(d4), sl4, sr4, n4q, n4c);
    end
    @(posedge clk);
    #1;
    m8_q = n8q; m8_co = n8c; m4_q = n4q; m4_co = n4c;
    check_all(tag);
  endtask

  // Asynchronous pulse placed between edges; called just after a posedge.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    set_reset_model();
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive8(input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic l, input logic r);
    en8 = e; mode8 = m; d8 = dd; sl8 = l; sr8 = r;
  endtask

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    logic       exp_co;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 3'b001, 8'h96, 1'b0, 1'b0, 8'h96, 1'b0}); // load
    vecs.push_back('{1'b1, 3'b010, 8'hFF, 1'b1, 1'b0, 8'h2D, 1'b1}); // shl sin_l=1
    vecs.push_back('{1'b1, 3'b101, 8'h00, 1'b0, 1'b1, 8'h96, 1'b1}); // ror
    vecs.push_back('{1'b1, 3'b110, 8'h00, 1'b1, 1'b1, 8'hCB, 1'b0}); // asr
    vecs.push_back('{1'b1, 3'b011, 8'hFF, 1'b1, 1'b0, 8'h65, 1'b1}); // shr sin_r=0
    vecs.push_back('{1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 8'h65, 1'b1}); // gated load
    vecs.push_back('{1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 8'h65, 1'b1}); // gated clear x3
    vecs.push_back('{1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 8'h65, 1'b1});
    vecs.push_back('{1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 8'h65, 1'b1});
    vecs.push_back('{1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}); // clear
    vecs.push_back('{1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0}); // load 0x81
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1}); // 8 x rol
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h18, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h60, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1});

    // Reset asserted between edges takes effect without a clock
    #3;
    rst = 1'b1;
    #1;
    set_reset_model();
    chk("reset q8", 32'(q8), 32'h5A);
    chk("reset nq8", 32'(nq8), 32'hA5);
    chk("reset co8", 32'(co8), 32'h0);
    check_all("reset");

    // Edges while rst is held must not change anything
    drive8(1'b1, 3'b111, 8'h00, 1'b1, 1'b1);
    en4 = 1'b1; mode4 = 3'b001; d4 = 4'hF;
    tick("rst_hold");
    tick("rst_hold");
    rst = 1'b0;
    en4 = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive8(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
      tick($sformatf("model v%0d", i));
      chk($sformatf("vec%0d q", i), 32'(q8), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d co", i), 32'(co8), 32'(vecs[i].exp_co));
      chk($sformatf("vec%0d zero", i), 32'(z8), 32'(vecs[i].exp_q == 8'h00));
    end

    // 4-bit instance: rotate-left and arithmetic-shift-right of 0x9
    en8 = 1'b0;
    en4 = 1'b1; mode4 = 3'b001; d4 = 4'h9;
    tick("w4 load");
    mode4 = 3'b100;
    tick("w4 rol");
    chk("w4 rol q", 32'(q4), 32'h3);
    chk("w4 rol co", 32'(co4), 32'h1);
    mode4 = 3'b001; d4 = 4'h9;
    tick("w4 load2");
    mode4 = 3'b110;
    tick("w4 asr");
    chk("w4 asr q", 32'(q4), 32'hC);
    chk("w4 asr co", 32'(co4), 32'h1);

    // Reset in the middle of a continuous shift-left
    drive8(1'b1, 3'b001, 8'h0F, 1'b1, 1'b0);
    tick("mid load");
    mode8 = 3'b010;
    for (int i = 0; i < 3; i++) tick("mid shl");
    pulse_reset("mid rst");
    chk("mid rst q8", 32'(q8), 32'h5A);
    chk("mid rst co8", 32'(co8), 32'h0);
    tick("mid resume");
    chk("mid resume q8", 32'(q8), 32'hB5);
    chk("mid resume co8", 32'(co8), 32'h0);

    // Randomised traffic on both instances, with occasional async reset pulses
    for (int i = 0; i < 400; i++) begin
      drive8(($urandom % 4) != 0, 3'($urandom % 8), 8'($urandom), 1'($urandom), 1'($urandom));
      en4 = ($urandom % 4) != 0; mode4 = 3'($urandom % 8); d4 = 4'($urandom);
      sl4 = 1'($urandom); sr4 = 1'($urandom);
      tick($sformatf("rand%0d", i));
      if ($urandom % 50 == 0) pulse_reset($sformatf("rand rst%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register. It generalises the single-bit enabled storage element to a WIDTH-bit word with selectable hold, load, shift, rotate and clear modes. It provides true and complemented outputs plus a registered shift-out flag. It serves as the datapath register for the lab serial/parallel converters and the shift-and-add multiplier exercises.

## Interface

Parameters:
- WIDTH, default 8: word width; legal range is WIDTH >= 2.
- RESET_VALUE, default 0: value loaded into q on reset; WIDTH bits wide.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst, input, 1: reset; asynchronous, active-high.
- en, input, 1: synchronous enable; when 0, all state holds.
- mode, input, 3: operation select, sampled at the clock edge.
- d, input, WIDTH: parallel load data.
- sin_l, input, 1: bit inserted at the LSB on a logical shift left.
- sin_r, input, 1: bit inserted at the MSB on a logical shift right.
- q, output, WIDTH: register contents.
- nq, output, WIDTH: bitwise complement of q, always ~q.
- co, output, 1: registered carry-out, the last bit shifted or rotated out.
- zero, output, 1: combinational flag, high when q == 0.

## Operation

- State is q[WIDTH-1:0] and co. Both are updated only at a rising clk edge with en=1 and rst=0.
- Modes, evaluated at an edge with en=1:
  - 000 hold: q and co are unchanged.
  - 001 load: q <= d; co <= 0.
  - 010 shift left logical: q <= {q[W-2:0], sin_l}; co <= q[W-1].
  - 011 shift right logical: q <= {sin_r, q[W-1:1]}; co <= q[0].
  - 100 rotate left: q <= {q[W-2:0], q[W-1]}; co <= q[W-1].
  - 101 rotate right: q <= {q[0], q[W-1:1]}; co <= q[0].
  - 110 arithmetic shift right: q <= {q[W-1], q[W-1:1]}; co <= q[0].
  - 111 clear: q <= 0; co <= 0.
- en=0 holds q and co for every mode value, including load and clear.
- sin_l and sin_r are ignored in every mode except 010 and 011 respectively.
- nq is always exactly ~q: both are derived from the same state, so no cycle exists in which nq disagrees with q. There is no forbidden input state, unlike a cross-coupled latch.
- No X propagation from unused inputs: d is ignored in every mode except 001.

## Timing

- Reset:
  - rst rising sets q = RESET_VALUE, nq = ~RESET_VALUE and co = 0 immediately, independent of clk.
  - zero follows q.
  - While rst=1, clock edges have no effect.
  - Reset asserted mid-sequence discards the operation in flight; no partial update occurs.
- Latency:
  - One cycle for every mode: the result is visible on q, nq and co just after the edge that samples mode/en.
  - zero settles combinationally after q.
- First edge after rst deasserts: behaves as a normal edge. No dead cycle is inserted.
- Back-to-back operations: each edge uses the q produced by the previous edge, so consecutive shifts chain with no bubbles.
- Wrap-around: rotates lose no bits. WIDTH consecutive rotates in one direction return q to its original value, and co equals the bit that last wrapped.

## Test plan

- Reset and load (WIDTH=8, RESET_VALUE=0x5A):
  - Assert rst between edges -> q=0x5A, nq=0xA5, co=0 before the next edge.
  - Release rst; load d=0x96 -> q=0x96, nq=0x69, co=0.
- Shift chain from q=0x96:
  - Shift left with sin_l=1 -> q=0x2D, co=1.
  - Rotate right -> q=0x96, co=1.
  - Arithmetic shift right -> q=0xCB, co=0.
  - Shift right logical with sin_r=0 -> q=0x65, co=1.
- Enable gating: from q=0x65, apply en=0 with mode=001 (d=0xFF) and then with mode=111 for 3 edges -> q stays 0x65 and co stays 1. Then en=1 with mode=111 -> q=0x00, zero=1, co=0.
- Rotate wrap: load 0x81, then 8 consecutive rotate-left edges -> the sequence is 0x03, 0x06, ... 0x81. After the eighth edge q=0x81 and co=1.
- Reset mid-operation: during continuous shift-left with sin_l=1, pulse rst asynchronously between edges -> q jumps to RESET_VALUE and co=0 at once. Shifting resumes from RESET_VALUE on the first edge after release.
- Parameter sweep (WIDTH=4, RESET_VALUE=0):
  - Load 0x9, then rotate left -> q=0x3, co=1.
  - Arithmetic shift right of 0x9 -> q=0xC, co=1.
  - Check nq == ~q on every cycle of every test.
